// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the femtoRV32 ALU control / RV32M engine.
//   - ALU_SEL_* : 4-bit ALU selection codes driven to the execute-stage ALU
//   - ALUOP_*   : 2-bit main-decoder alu_op classes
//   - M_*       : RV32M funct3 codes
//   - mdu_state_e : multiply/divide FSM states
package alu_pkg;

   localparam logic [3:0] ALU_SEL_AND    = 4'b0000;
   localparam logic [3:0] ALU_SEL_OR     = 4'b0001;
   localparam logic [3:0] ALU_SEL_ADD    = 4'b0010;
   localparam logic [3:0] ALU_SEL_XOR    = 4'b0011;
   localparam logic [3:0] ALU_SEL_SLL    = 4'b0100;
   localparam logic [3:0] ALU_SEL_SRL    = 4'b0101;
   localparam logic [3:0] ALU_SEL_SUB    = 4'b0110;
   localparam logic [3:0] ALU_SEL_SRA    = 4'b0111;
   localparam logic [3:0] ALU_SEL_SLT    = 4'b1000;
   localparam logic [3:0] ALU_SEL_SLTU   = 4'b1001;
   localparam logic [3:0] ALU_SEL_PASS_B = 4'b1111;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [2:0] M_MUL    = 3'b000;
   localparam logic [2:0] M_MULH   = 3'b001;
   localparam logic [2:0] M_MULHSU = 3'b010;
   localparam logic [2:0] M_MULHU  = 3'b011;
   localparam logic [2:0] M_DIV    = 3'b100;
   localparam logic [2:0] M_DIVU   = 3'b101;
   localparam logic [2:0] M_REM    = 3'b110;
   localparam logic [2:0] M_REMU   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_CALC = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide engine (one bit per cycle).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_i           accepted request (already qualified by ready and m_op)
//   funct3_i          M-op select, latched on start
//   op_a_i, op_b_i    operands, latched on start
//   flush_i           synchronous abort, returns to IDLE
//   rsp_ready_i       consumer takes the result in DONE
//   req_ready_o       engine idle (forced low while in reset)
//   rsp_valid_o       result available (DONE)
//   rsp_result_o      registered result
module mdu_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            flush_i,
   input  logic            rsp_ready_i,
   output logic            req_ready_o,
   output logic            rsp_valid_o,
   output logic [XLEN-1:0] rsp_result_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          f3_q, f3_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic [XLEN-1:0]     b_q, b_d;      // operand b, then divisor/multiplicand magnitude
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic [XLEN-1:0]     quo_q, quo_d;
   logic [XLEN-1:0]     rem_q, rem_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     res_q, res_d;

   logic              is_div, is_rem, sgn_a, sgn_b, a_neg, b_neg, div_zero, ovf;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     rem_sh, diff, mul_sum;
   logic [2*XLEN-1:0] prod_fix;

   assign is_div = f3_q[2];
   assign is_rem = f3_q[2] & f3_q[1];
   assign sgn_a  = (f3_q == M_MULH) | (f3_q == M_MULHSU) | (f3_q == M_DIV) | (f3_q == M_REM);
   assign sgn_b  = (f3_q == M_MULH) | (f3_q == M_DIV) | (f3_q == M_REM);
   assign a_neg  = sgn_a & a_q[XLEN-1];
   assign b_neg  = sgn_b & b_q[XLEN-1];
   assign mag_a  = a_neg ? (~a_q + 1'b1) : a_q;
   assign mag_b  = b_neg ? (~b_q + 1'b1) : b_q;
   assign div_zero = (b_q == '0);
   assign ovf    = ((f3_q == M_DIV) | (f3_q == M_REM)) & (a_q == MIN_NEG) & (&b_q);

   // Restoring divide step: bring in the next dividend bit, trial-subtract.
   // A set top bit of diff means the subtraction went negative.
   assign rem_sh = {rem_q, quo_q[XLEN-1]};
   assign diff   = rem_sh - {1'b0, b_q};

   // Shift-add multiply: multiplier sits in the low half and is consumed LSB first.
   assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
   assign prod_fix = neg_q ? (~prod_q + 1'b1) : prod_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      neg_d   = neg_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               f3_d    = funct3_i;
               a_d     = op_a_i;
               b_d     = op_b_i;
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            // Remainder follows the dividend; everything else is sign(a)^sign(b).
            neg_d = is_rem ? a_neg : (a_neg ^ b_neg);
            if (is_div && div_zero) begin
               res_d   = is_rem ? a_q : '1;
               state_d = ST_DONE;
            end else if (ovf) begin
               res_d   = is_rem ? '0 : a_q;
               state_d = ST_DONE;
            end else begin
               prod_d  = {{XLEN{1'b0}}, mag_a};
               quo_d   = mag_a;
               rem_d   = '0;
               b_d     = mag_b;
               cnt_d   = CW'(XLEN-1);
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (is_div) begin
               rem_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
            end else begin
               prod_d = {mul_sum, prod_q[XLEN-1:1]};
            end
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_FIX: begin
            if (!is_div) begin
               res_d = (f3_q == M_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            end else if (is_rem) begin
               res_d = neg_q ? (~rem_q + 1'b1) : rem_q;
            end else begin
               res_d = neg_q ? (~quo_q + 1'b1) : quo_q;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (rsp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort wins over accept and over consume.
      if (flush_i) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
      end
   end

   assign req_ready_o  = rst_n & (state_q == ST_IDLE);
   assign rsp_valid_o  = (state_q == ST_DONE);
   assign rsp_result_o = res_q;

endmodule

// File: rtl/alu_control_mdu.sv
// alu_control_mdu: RV32I ALU-select decode plus optional iterative RV32M engine.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   alu_op_i, funct3_i,
//   inst_30_i, inst_25_i,
//   is_lui_i                   instruction fields from the main decoder
//   alu_sel_o                  4-bit ALU selection (combinational)
//   m_op_o                     instruction is RV32M (combinational)
//   op_a_i, op_b_i             rs1/rs2 values
//   req_valid_i / req_ready_o  M-op request handshake
//   rsp_valid_o / rsp_ready_i  M-op response handshake
//   rsp_result_o               M-op result
//   flush_i                    synchronous abort of any M-op
module alu_control_mdu
   import alu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      alu_op_i,
   input  logic [2:0]      funct3_i,
   input  logic            inst_30_i,
   input  logic            inst_25_i,
   input  logic            is_lui_i,
   output logic [3:0]      alu_sel_o,
   output logic            m_op_o,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_result_o,
   input  logic            flush_i
);

   always_comb begin
      alu_sel_o = ALU_SEL_AND;
      if (is_lui_i) begin
         alu_sel_o = ALU_SEL_PASS_B;
      end else begin
         case (alu_op_i)
            ALUOP_MEM: alu_sel_o = ALU_SEL_ADD;
            ALUOP_BR:  alu_sel_o = ALU_SEL_SUB;
            ALUOP_R, ALUOP_I: begin
               case (funct3_i)
                  // ADDI has no SUB form; inst_30 is an immediate bit there.
                  3'b000: alu_sel_o = (alu_op_i == ALUOP_R && inst_30_i) ? ALU_SEL_SUB : ALU_SEL_ADD;
                  3'b001: alu_sel_o = ALU_SEL_SLL;
                  3'b010: alu_sel_o = ALU_SEL_SLT;
                  3'b011: alu_sel_o = ALU_SEL_SLTU;
                  3'b100: alu_sel_o = ALU_SEL_XOR;
                  3'b101: alu_sel_o = inst_30_i ? ALU_SEL_SRA : ALU_SEL_SRL;
                  3'b110: alu_sel_o = ALU_SEL_OR;
                  3'b111: alu_sel_o = ALU_SEL_AND;
                  default: alu_sel_o = ALU_SEL_AND;
               endcase
            end
            default: alu_sel_o = ALU_SEL_AND;
         endcase
      end
   end

   generate
      if (ENABLE_M) begin : g_mdu
         logic start;
         assign m_op_o = (alu_op_i == ALUOP_R) & inst_25_i;
         assign start  = req_valid_i & req_ready_o & m_op_o;

         mdu_iter #(.XLEN(XLEN)) u_mdu (
            .clk          (clk),
            .rst_n        (rst_n),
            .start_i      (start),
            .funct3_i     (funct3_i),
            .op_a_i       (op_a_i),
            .op_b_i       (op_b_i),
            .flush_i      (flush_i),
            .rsp_ready_i  (rsp_ready_i),
            .req_ready_o  (req_ready_o),
            .rsp_valid_o  (rsp_valid_o),
            .rsp_result_o (rsp_result_o)
         );
      end else begin : g_no_mdu
         assign m_op_o       = 1'b0;
         assign req_ready_o  = 1'b0;
         assign rsp_valid_o  = 1'b0;
         assign rsp_result_o = '0;
      end
   endgenerate

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu (XLEN=32, ENABLE_M=1).
module tb_alu_control_mdu;

   logic        clk;
   logic        rst_n;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic        inst_30, inst_25, is_lui;
   logic [3:0]  alu_sel;
   logic        m_op;
   logic [31:0] op_a, op_b;
   logic        req_valid, req_ready, rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic        flush;

   int n_cmp = 0;
   int n_err = 0;

   alu_control_mdu #(.XLEN(32), .ENABLE_M(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_op_i     (alu_op),
      .funct3_i     (funct3),
      .inst_30_i    (inst_30),
      .inst_25_i    (inst_25),
      .is_lui_i     (is_lui),
      .alu_sel_o    (alu_sel),
      .m_op_o       (m_op),
      .op_a_i       (op_a),
      .op_b_i       (op_b),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_result_o (rsp_result),
      .flush_i      (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dec(input string tag, input logic [1:0] op, input logic [2:0] f3,
                      input logic i30, input logic lui, input logic [3:0] exp);
      alu_op = op; funct3 = f3; inst_30 = i30; is_lui = lui; inst_25 = 1'b0;
      #1;
      chk(tag, {28'd0, alu_sel}, {28'd0, exp});
   endtask

   // Issue one M-op, measure cycles from the accept edge to rsp_valid,
   // optionally hold rsp_ready low for 'hold' cycles, then consume.
   task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
      int lat;
      alu_op = 2'b10; inst_25 = 1'b1; inst_30 = 1'b0; is_lui = 1'b0;
      funct3 = f3; op_a = a; op_b = b; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, rsp_result, exp);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
         chk({tag, "_hold_res"}, rsp_result, exp);
         chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_idle_valid"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      int seen;
      rst_n = 1'b0; alu_op = 2'b00; funct3 = 3'b000; inst_30 = 1'b0; inst_25 = 1'b0;
      is_lui = 1'b0; op_a = '0; op_b = '0; req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_result", rsp_result, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

      // Decode sweep
      dec("dec_sra",      2'b10, 3'b101, 1'b1, 1'b0, 4'b0111);
      dec("dec_addi_i30", 2'b11, 3'b000, 1'b1, 1'b0, 4'b0010);
      dec("dec_lui",      2'b10, 3'b101, 1'b1, 1'b1, 4'b1111);
      dec("dec_branch",   2'b01, 3'b000, 1'b0, 1'b0, 4'b0110);
      dec("dec_mem",      2'b00, 3'b010, 1'b1, 1'b0, 4'b0010);
      dec("dec_sub",      2'b10, 3'b000, 1'b1, 1'b0, 4'b0110);
      dec("dec_srli",     2'b11, 3'b101, 1'b0, 1'b0, 4'b0101);
      dec("dec_srai",     2'b11, 3'b101, 1'b1, 1'b0, 4'b0111);
      dec("dec_slt",      2'b10, 3'b010, 1'b0, 1'b0, 4'b1000);
      dec("dec_sltu",     2'b11, 3'b011, 1'b0, 1'b0, 4'b1001);
      dec("dec_and",      2'b10, 3'b111, 1'b0, 1'b0, 4'b0000);
      dec("dec_or",       2'b11, 3'b110, 1'b0, 1'b0, 4'b0001);

      // m_op only for R-format with inst_25
      alu_op = 2'b10; inst_25 = 1'b1; #1;
      chk("mop_r", {31'd0, m_op}, 32'd1);
      alu_op = 2'b11; #1;
      chk("mop_i", {31'd0, m_op}, 32'd0);

      // req_valid without m_op is ignored
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      chk("nonm_ignored_ready", {31'd0, req_ready}, 32'd1);
      chk("nonm_ignored_valid", {31'd0, rsp_valid}, 32'd0);

      // Normal M-ops: XLEN+2 = 34 cycles
      run_m("mul",    3'b000, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 34, 0);
      run_m("mulhu",  3'b011, 32'hFFFF_FFFF, 32'd7, 32'h0000_0006, 34, 0);
      run_m("mulh",   3'b001, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 34, 0);
      run_m("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 34, 0);
      run_m("div",    3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, 0);
      run_m("rem",    3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34, 0);
      run_m("divu",   3'b101, 32'd100, 32'd7, 32'd14, 34, 0);
      run_m("remu",   3'b111, 32'd100, 32'd7, 32'd2, 34, 0);

      // Special cases: 1 cycle
      run_m("divu0",   3'b101, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
      run_m("rem0",    3'b110, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 0);
      run_m("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
      run_m("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);

      // Backpressure: 5 cycles held in DONE
      run_m("bp", 3'b000, 32'd3, 32'd5, 32'd15, 34, 5);

      // Flush at CALC cycle 10
      alu_op = 2'b10; inst_25 = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
      req_valid = 1'b1;
      tick();                      // accept -> PREP
      req_valid = 1'b0;
      tick();                      // CALC cycle 1
      repeat (9) tick();           // CALC cycle 10
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_ready", {31'd0, req_ready}, 32'd1);
      chk("flush_valid", {31'd0, rsp_valid}, 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (rsp_valid) seen = 1;
      end
      chk("flush_no_valid", seen, 0);
      run_m("post_flush_mul", 3'b000, 32'd3, 32'd5, 32'd15, 34, 0);

      // Reset pulse mid-CALC
      alu_op = 2'b10; inst_25 = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", {31'd0, req_ready}, 32'd0);
      chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_result", rsp_result, 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("midrst_release_ready", {31'd0, req_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (rsp_valid) seen = 1;
      end
      chk("midrst_no_valid", seen, 0);
      run_m("post_rst_mul", 3'b000, 32'd3, 32'd5, 32'd15, 34, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
